// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller.
// Freezes the front end on read-after-write and branch hazards, redirects
// the PC when a taken branch resolves, and counts stalled cycles. A sticky
// watchdog flag is raised if the pipe stays held for too long.
module pipe_stall_ctrl #(
  parameter int MAX_STALL = 64,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rw_stall,
  input  logic             jb_stall,
  input  logic             jb_resolve,
  input  logic             jb_taken,
  input  logic [31:0]      jb_target,
  input  logic             clr_stats,
  output logic             if_hold,
  output logic             dec_bubble,
  output logic             pc_load,
  output logic [31:0]      pc_load_addr,
  output logic             flush_if,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             deadlock
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RW_WAIT  = 2'd1,
    JB_WAIT  = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             hold;
  logic             take_branch;
  logic [RUN_W-1:0] run_cnt;

  assign take_branch = (state == JB_WAIT) && jb_resolve && jb_taken;

  // Hold is combinational on the current inputs so the PC freezes in the same cycle the hazard appears
  always_comb begin
    hold = 1'b0;
    if (!rst && (state != REDIRECT)) begin
      hold = rw_stall || jb_stall || ((state == JB_WAIT) && !jb_resolve);
    end
  end

  assign if_hold    = hold;
  assign dec_bubble = hold;
  assign pc_load    = !rst && (state == REDIRECT);
  assign flush_if   = !rst && (state == REDIRECT);

  // Next-state logic; branch hazards take priority and REDIRECT lasts exactly one cycle
  always_comb begin
    state_next = state;
    unique case (state)
      RUN: begin
        if (jb_stall)      state_next = JB_WAIT;
        else if (rw_stall) state_next = RW_WAIT;
      end
      RW_WAIT: begin
        if (jb_stall)       state_next = JB_WAIT;
        else if (!rw_stall) state_next = RUN;
      end
      JB_WAIT: begin
        if (jb_resolve) state_next = jb_taken ? REDIRECT : RUN;
      end
      REDIRECT: begin
        state_next = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Capture the redirect target only when a taken branch resolves while waiting on it
  always_ff @(posedge clk) begin
    if (rst)              pc_load_addr <= 32'h0;
    else if (take_branch) pc_load_addr <= jb_target;
  end

  // Cumulative stall counter; clear wins over increment and the count saturates instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || clr_stats)                  stall_cnt <= '0;
    else if (hold && (stall_cnt != '1))    stall_cnt <= stall_cnt + CNT_W'(1);
  end

  // Length of the current unbroken hold run, saturating at the watchdog limit
  always_ff @(posedge clk) begin
    if (rst)                                    run_cnt <= '0;
    else if (!hold)                             run_cnt <= '0;
    else if (run_cnt != RUN_W'(MAX_STALL))      run_cnt <= run_cnt + RUN_W'(1);
  end

  // Sticky watchdog: set on the edge the run reaches the limit, only reset clears it
  always_ff @(posedge clk) begin
    if (rst)                                           deadlock <= 1'b0;
    else if (hold && (run_cnt == RUN_W'(MAX_STALL - 1))) deadlock <= 1'b1;
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Testbench for pipe_stall_ctrl: a default instance and a small one
// (MAX_STALL=4, CNT_W=4) share the same stimulus.
module tb_pipe_stall_ctrl;

  logic        clk;
  logic        rst;
  logic        rw_stall;
  logic        jb_stall;
  logic        jb_resolve;
  logic        jb_taken;
  logic [31:0] jb_target;
  logic        clr_stats;

  logic        if_hold, dec_bubble, pc_load, flush_if, deadlock;
  logic [31:0] pc_load_addr;
  logic [31:0] stall_cnt;

  logic        if_hold_s, dec_bubble_s, pc_load_s, flush_if_s, deadlock_s;
  logic [31:0] pc_load_addr_s;
  logic [3:0]  stall_cnt_s;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        rst, rw, jb, res, tk;
    logic [31:0] tgt;
    logic        clr;
    logic        hold, load;
    logic [31:0] addr, cnt;
    logic [3:0]  cs;
    logic        dls;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  logic cap_hold, cap_bub, cap_load, cap_flush, cap_hold_s, cap_load_s;
  int   cur_idx;

  pipe_stall_ctrl dut (
    .clk(clk), .rst(rst), .rw_stall(rw_stall), .jb_stall(jb_stall),
    .jb_resolve(jb_resolve), .jb_taken(jb_taken), .jb_target(jb_target),
    .clr_stats(clr_stats), .if_hold(if_hold), .dec_bubble(dec_bubble),
    .pc_load(pc_load), .pc_load_addr(pc_load_addr), .flush_if(flush_if),
    .stall_cnt(stall_cnt), .deadlock(deadlock)
  );

  pipe_stall_ctrl #(.MAX_STALL(4), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .rw_stall(rw_stall), .jb_stall(jb_stall),
    .jb_resolve(jb_resolve), .jb_taken(jb_taken), .jb_target(jb_target),
    .clr_stats(clr_stats), .if_hold(if_hold_s), .dec_bubble(dec_bubble_s),
    .pc_load(pc_load_s), .pc_load_addr(pc_load_addr_s), .flush_if(flush_if_s),
    .stall_cnt(stall_cnt_s), .deadlock(deadlock_s)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  function automatic vec_t mk(input logic r, rw, jb, res, tk, input logic [31:0] tgt,
                              input logic clr, hold, load, input logic [31:0] addr, cnt,
                              input logic [3:0] cs, input logic dls);
    vec_t v;
    v.rst = r; v.rw = rw; v.jb = jb; v.res = res; v.tk = tk; v.tgt = tgt; v.clr = clr;
    v.hold = hold; v.load = load; v.addr = addr; v.cnt = cnt; v.cs = cs; v.dls = dls;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic driveInputs(input logic r, rw, jb, res, tk, input logic [31:0] tgt, input logic clr);
    rst = r; rw_stall = rw; jb_stall = jb; jb_resolve = res; jb_taken = tk;
    jb_target = tgt; clr_stats = clr;
  endtask

  // Drive one vector mid-cycle, capture combinational outputs before the edge, check after it
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    driveInputs(v.rst, v.rw, v.jb, v.res, v.tk, v.tgt, v.clr);
    exp_q.push_back(v);
    #1;
    cap_hold   = if_hold;
    cap_bub    = dec_bubble;
    cap_load   = pc_load;
    cap_flush  = flush_if;
    cap_hold_s = if_hold_s;
    cap_load_s = pc_load_s;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkOutput();
    vec_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL v%0d scoreboard: got empty expected entry", cur_idx);
      return;
    end
    e = exp_q.pop_front();
    chk($sformatf("v%0d if_hold", cur_idx),        {31'b0, cap_hold},   {31'b0, e.hold});
    chk($sformatf("v%0d dec_bubble", cur_idx),     {31'b0, cap_bub},    {31'b0, e.hold});
    chk($sformatf("v%0d pc_load", cur_idx),        {31'b0, cap_load},   {31'b0, e.load});
    chk($sformatf("v%0d flush_if", cur_idx),       {31'b0, cap_flush},  {31'b0, e.load});
    chk($sformatf("v%0d small if_hold", cur_idx),  {31'b0, cap_hold_s}, {31'b0, e.hold});
    chk($sformatf("v%0d small pc_load", cur_idx),  {31'b0, cap_load_s}, {31'b0, e.load});
    chk($sformatf("v%0d pc_load_addr", cur_idx),   pc_load_addr,        e.addr);
    chk($sformatf("v%0d stall_cnt", cur_idx),      stall_cnt,           e.cnt);
    chk($sformatf("v%0d small stall_cnt", cur_idx), {28'b0, stall_cnt_s}, {28'b0, e.cs});
    chk($sformatf("v%0d deadlock", cur_idx),       {31'b0, deadlock},   32'd0);
    chk($sformatf("v%0d small deadlock", cur_idx), {31'b0, deadlock_s}, {31'b0, e.dls});
  endtask

  // Main test: vector table, then the long watchdog run on the default instance
  initial begin
    driveInputs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    //            rst rw jb res tk tgt            clr hold load addr          cnt cs dls
    vecs.push_back(mk(1, 1, 1, 1, 1, 32'hFFFF_0000, 0, 0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 1, 0, 32'h0,        1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 1, 0, 32'h0,        2, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 1, 0, 32'h0,        3, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,        3, 3, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0,         0, 1, 0, 32'h0,        4, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         0, 1, 0, 32'h0,        5, 5, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0000_1040, 0, 0, 0, 32'h0000_1040, 5, 5, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 0, 1, 32'h0000_1040, 5, 5, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0000_1040, 5, 5, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0,         0, 1, 0, 32'h0000_1040, 6, 6, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0, 32'h0000_1040, 6, 6, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0000_1040, 6, 6, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0000_2222, 0, 0, 0, 32'h0000_1040, 6, 6, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0000_1040, 6, 6, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,         0, 1, 0, 32'h0000_1040, 7, 7, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         0, 1, 0, 32'h0000_1040, 8, 8, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0000_2000, 0, 0, 0, 32'h0000_2000, 8, 8, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0,         0, 0, 1, 32'h0000_2000, 8, 8, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0000_2000, 8, 8, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0,         0, 1, 0, 32'h0000_2000, 9, 9, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0,         0, 1, 0, 32'h0000_2000, 10, 10, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0,         0, 1, 0, 32'h0000_2000, 11, 11, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0,         0, 1, 0, 32'h0000_2000, 12, 12, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         1, 1, 0, 32'h0000_2000, 0, 0, 1));
    for (int k = 1; k <= 17; k++) begin
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0000_2000,
                        32'(k), (k > 15) ? 4'd15 : 4'(k), 1));
    end
    vecs.push_back(mk(1, 1, 1, 0, 0, 32'h0,         0, 0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0,         0, 1, 0, 32'h0,        1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0000_3000, 0, 0, 0, 32'h0000_3000, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,        0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      cur_idx = i;
      applyStimulus(vecs[i]);
    end

    // Long hold on the default instance: watchdog must trip on exactly the 64th held edge
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      driveInputs(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      if (k == 63) chk("watchdog before limit", {31'b0, deadlock}, 32'd0);
      if (k == 64) chk("watchdog at limit",     {31'b0, deadlock}, 32'd1);
    end
    chk("stall_cnt after 64 holds", stall_cnt, 32'd64);

    // Statistics clear must not touch the sticky flag
    @(negedge clk);
    driveInputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    chk("stall_cnt after clr_stats", stall_cnt, 32'd0);
    chk("watchdog after clr_stats", {31'b0, deadlock}, 32'd1);

    // Reset mid JB_WAIT clears the flag and leaves no redirect behind
    @(negedge clk);
    driveInputs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("watchdog after reset", {31'b0, deadlock}, 32'd0);
    @(negedge clk);
    driveInputs(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_5000, 1'b0);
    #1;
    chk("hold after reset in JB_WAIT", {31'b0, if_hold}, 32'd0);
    @(posedge clk);
    #1;
    chk("no redirect after reset", {31'b0, pc_load}, 32'd0);
    chk("addr untouched after reset", pc_load_addr, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
